// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
// TXDATA stores are queued in a small FIFO; STATUS loads report FIFO and line state.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (line low) for one bit period
// DATA   | eight data bits, LSB first, one bit period each
// STOP   | stop bit (line high) for one bit period
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] bit_tmr;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic        hit;
  logic        sel_status;
  logic        is_write;
  logic        push_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        bit_done;
  logic [31:0] status_word;

  assign hit        = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_status = mem_addr[2];
  assign is_write   = |mem_wstrb;
  assign push_req   = hit && !sel_status && mem_wstrb[0];
  assign fifo_full  = (fifo_cnt == DEPTH_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // A push to a full FIFO stalls the bus; it only proceeds once the registered count drops.
  assign accept = hit && !mem_ready && !(push_req && fifo_full);
  assign push   = accept && push_req;
  assign pop    = (state == ST_IDLE) && !fifo_empty;

  assign tx_busy     = (state != ST_IDLE);
  assign bit_done    = (bit_tmr == BIT_LAST);
  assign status_word = {16'h0000, 8'(fifo_cnt), 5'b00000, tx_busy, fifo_empty, fifo_full};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_write && sel_status) ? status_word : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      bit_tmr   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_tmr <= '0;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            bit_tmr <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            bit_tmr   <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            bit_tmr <= '0;
            state   <= ST_IDLE;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        default: begin
          bit_tmr <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Line level is a pure decode of registered state, so reset forces it high at once.
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift_reg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          CLK_DIV = 4;
  localparam int          DEPTH   = 4;
  localparam int          FRAME   = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b1;
  logic [31:0] mem_addr = BASE;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        tx_busy;

  int total = 0;
  int bad   = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: byte queue plus position inside the current 10-bit frame.
  logic [7:0]  m_q[$];
  logic [7:0]  m_log[$];
  logic [7:0]  m_cur = 8'h00;
  int          m_pos = -1;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  int          m_cnt;
  logic        m_hit, m_wr, m_preq, m_acc;
  logic [31:0] m_status;
  logic        exp_tx;
  int          m_k;

  always @(posedge clk) begin
    if (!resetn) begin
      m_q.delete();
      m_pos   = -1;
      m_ready = 1'b0;
      m_rdata = 32'h0;
    end else begin
      m_cnt    = m_q.size();
      m_hit    = mem_valid && (mem_addr[31:3] == BASE[31:3]);
      m_wr     = (mem_wstrb != 4'h0);
      m_preq   = m_hit && !mem_addr[2] && mem_wstrb[0];
      m_acc    = m_hit && !m_ready && !(m_preq && (m_cnt == DEPTH));
      m_status = 32'(m_cnt) * 256 + ((m_pos >= 0) ? 4 : 0)
               + ((m_cnt == 0) ? 2 : 0) + ((m_cnt == DEPTH) ? 1 : 0);
      if (m_pos < 0) begin
        if (m_cnt > 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end
      if (m_acc && m_preq) begin
        m_q.push_back(mem_wdata[7:0]);
        m_log.push_back(mem_wdata[7:0]);
      end
      m_rdata = (m_acc && !m_wr && mem_addr[2]) ? m_status : 32'h0;
      m_ready = m_acc;
    end
    #1;
    if (m_pos < 0) exp_tx = 1'b1;
    else begin
      m_k = m_pos / CLK_DIV;
      exp_tx = (m_k == 0) ? 1'b0 : (m_k == 9) ? 1'b1 : m_cur[m_k-1];
    end
    check("model mem_ready", 32'(mem_ready), 32'(m_ready));
    check("model mem_rdata", mem_rdata, m_rdata);
    check("model uart_tx", 32'(uart_tx), 32'(exp_tx));
    check("model tx_busy", 32'(tx_busy), 32'(m_pos >= 0));
  end

  // Independent line receiver, sampling mid-bit.
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  always begin
    @(posedge clk); #1;
    if (resetn && uart_tx === 1'b0) begin
      repeat (CLK_DIV / 2) begin @(posedge clk); #1; end
      for (int k = 0; k < 8; k++) begin
        repeat (CLK_DIV) begin @(posedge clk); #1; end
        rx_b[k] = uart_tx;
      end
      repeat (CLK_DIV) begin @(posedge clk); #1; end
      rx_q.push_back(rx_b);
    end
  end

  task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int budget, output logic [31:0] rd, output bit acked,
                        output int cyc);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    acked = 1'b0; rd = 32'h0; cyc = 0;
    while (!acked && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) begin
        acked = 1'b1;
        rd = mem_rdata;
      end
    end
    @(negedge clk);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  logic [31:0] rd;
  bit          ok;
  int          cyc;
  int          nbusy;
  logic [39:0] line;
  logic [7:0]  bp_bytes[6];
  bit          done;

  initial begin
    bp_bytes = '{8'hA1, 8'h3C, 8'h00, 8'hFF, 8'h5A, 8'h96};

    // reset with a hit pending on the bus
    repeat (4) @(posedge clk);
    #1;
    check("reset uart_tx", 32'(uart_tx), 32'h1);
    check("reset tx_busy", 32'(tx_busy), 32'h0);
    check("reset mem_ready", 32'(mem_ready), 32'h0);
    @(negedge clk);
    mem_valid = 1'b0; resetn = 1'b1;
    bus_op(BASE + 4, 0, 4'h0, 20, rd, ok, cyc);
    check("reset status ack", 32'(ok), 32'h1);
    check("reset status", rd, 32'h0000_0002);

    // single frame
    bus_op(BASE, 32'h55, 4'b0001, 20, rd, ok, cyc);
    check("frame ack", 32'(ok), 32'h1);
    check("frame ack latency", 32'(cyc), 32'h1);
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i < 40) line[i] = uart_tx;
      if (tx_busy) nbusy++;
    end
    check("frame pattern", line[31:0], 32'hF0F0_F0F0);
    check("frame pattern hi", 32'(line[39:32]), 32'hF0);
    check("frame busy cycles", 32'(nbusy), 32'd40);
    check("frame line idle", 32'(uart_tx), 32'h1);

    // back-pressure
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      bus_op(BASE, 32'(bp_bytes[i]), 4'b0001, 20, rd, ok, cyc);
      check("bp ack", 32'(ok), 32'h1);
    end
    bus_op(BASE + 4, 0, 4'h0, 20, rd, ok, cyc);
    check("bp status full", rd, 32'h0000_0405);
    bus_op(BASE, 32'(bp_bytes[5]), 4'b0001, 300, rd, ok, cyc);
    check("bp 6th ack", 32'(ok), 32'h1);
    check("bp 6th delayed", 32'(cyc > 20), 32'h1);
    repeat (6 * (FRAME + 1) + 20) @(negedge clk);
    check("bp rx count", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check("bp rx byte", 32'(rx_q[i]), 32'(bp_bytes[i]));

    // decode
    bus_op(BASE + 8, 32'h77, 4'b0001, 6, rd, ok, cyc);
    check("decode base+8 no ack", 32'(ok), 32'h0);
    bus_op(32'h0000_1000, 32'h77, 4'b0001, 6, rd, ok, cyc);
    check("decode low addr no ack", 32'(ok), 32'h0);
    bus_op(BASE + 4, 32'h77, 4'b0001, 6, rd, ok, cyc);
    check("decode status write ack", 32'(ok), 32'h1);
    bus_op(BASE, 0, 4'h0, 6, rd, ok, cyc);
    check("decode txdata read ack", 32'(ok), 32'h1);
    check("decode txdata read", rd, 32'h0);
    bus_op(BASE + 4, 0, 4'h0, 6, rd, ok, cyc);
    check("decode status", rd, 32'h0000_0002);

    // strobe without byte 0
    bus_op(BASE, 32'h0000_AA00, 4'b0010, 6, rd, ok, cyc);
    check("strobe ack", 32'(ok), 32'h1);
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (tx_busy || !uart_tx) nbusy++;
    end
    check("strobe no frame", 32'(nbusy), 32'h0);

    // reset mid-frame
    bus_op(BASE, 32'hC3, 4'b0001, 20, rd, ok, cyc);
    bus_op(BASE, 32'h81, 4'b0001, 20, rd, ok, cyc);
    bus_op(BASE, 32'h7E, 4'b0001, 20, rd, ok, cyc);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (m_pos >= 4 * CLK_DIV + 1 && m_pos < 5 * CLK_DIV) done = 1'b1;
    end
    check("midreset reached bit3", 32'(done), 32'h1);
    resetn = 1'b0;
    #1;
    check("midreset uart_tx", 32'(uart_tx), 32'h1);
    check("midreset tx_busy", 32'(tx_busy), 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bus_op(BASE + 4, 0, 4'h0, 6, rd, ok, cyc);
    check("midreset status", rd, 32'h0000_0002);
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx_busy || !uart_tx) nbusy++;
    end
    check("midreset no frames", 32'(nbusy), 32'h0);

    // randomized traffic
    rx_q.delete();
    m_log.delete();
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      int          sel;
      int          bud;
      sel = $urandom_range(0, 5);
      s = ($urandom_range(0, 3) == 0) ? 4'h0 :
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1;
      bud = 400;
      case (sel)
        0, 1:    a = BASE + 32'($urandom_range(0, 3));
        2:       a = BASE + 4 + 32'($urandom_range(0, 3));
        3:       begin a = BASE + 8; bud = 4; end
        4:       begin a = 32'h0000_1000; bud = 4; end
        default: a = BASE;
      endcase
      bus_op(a, $urandom, s, bud, rd, ok, cyc);
      if (bud > 4) check("rand hit ack", 32'(ok), 32'h1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (m_q.size() == 0 && m_pos < 0) done = 1'b1;
    end
    check("rand drain", 32'(done), 32'h1);
    repeat (20) @(negedge clk);
    check("rand rx count", 32'(rx_q.size()), 32'(m_log.size()));
    for (int i = 0; i < rx_q.size() && i < m_log.size(); i++)
      check("rand rx byte", 32'(rx_q[i]), 32'(m_log[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
